// File: rtl/window_feeder.sv
// Raster-scan 3x3 window generator that streams each complete window serially
// to an external median stage and captures the returned median.
module window_feeder #(
    parameter int width = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [width-1:0] PIX_IN,
    input  logic             PIX_VALID,
    output logic             PIX_READY,
    output logic [width-1:0] MED_DI,
    output logic             MED_DSI,
    output logic             MED_NRST,
    input  logic [width-1:0] MED_DO,
    input  logic             MED_DSO,
    output logic [width-1:0] RES_OUT,
    output logic             RES_VALID
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CLR  = 3'd1;
    localparam logic [2:0] S_FEED = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [3:0]       feed_q, feed_d;
    logic [width-1:0] res_q, res_d;

    logic [width-1:0] lb1_mem [IMG_W];
    logic [width-1:0] lb2_mem [IMG_W];
    // Window stored row-major: index 0 is the oldest row/oldest column.
    logic [width-1:0] win_q [9];
    logic [width-1:0] win_d [9];

    logic accept;
    logic win_done;

    assign PIX_READY = (state_q == S_IDLE) && !RST;
    assign accept    = PIX_READY && PIX_VALID;
    assign win_done  = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO);

    assign MED_DSI   = (state_q == S_FEED);
    assign MED_DI    = MED_DSI ? win_q[feed_q] : '0;
    assign MED_NRST  = !RST && (state_q != S_CLR);
    assign RES_OUT   = res_q;
    assign RES_VALID = (state_q == S_OUT);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        feed_d  = feed_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (win_done) begin
                        state_d = S_CLR;
                    end
                end
            end
            S_CLR: begin
                feed_d  = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                feed_d = feed_q + 1'b1;
                if (feed_q == 4'd8) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (MED_DSO) begin
                    res_d   = MED_DO;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[3*r]     = win_q[3*r + 1];
                win_d[3*r + 1] = win_q[3*r + 2];
            end
            win_d[2] = lb2_mem[col_q];
            win_d[5] = lb1_mem[col_q];
            win_d[8] = PIX_IN;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            feed_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            feed_q  <= feed_d;
            res_q   <= res_d;
        end
    end

    // Pixel storage is never reset; rows not yet refilled are masked by row<2.
    always_ff @(posedge CLK) begin
        win_q <= win_d;
        if (accept) begin
            lb2_mem[col_q] <= lb1_mem[col_q];
            lb1_mem[col_q] <= PIX_IN;
        end
    end

endmodule

// File: tb/tb_window_feeder.sv
// Directed bench for window_feeder: image model builds expected windows and
// medians, a responder plays the median stage, and observations are scored.
module tb_window_feeder;
    localparam int IW = 8;
    localparam int IH = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] PIX_IN = '0;
    logic       PIX_VALID = 1'b0;
    logic       PIX_READY;
    logic [7:0] MED_DI;
    logic       MED_DSI;
    logic       MED_NRST;
    logic [7:0] MED_DO;
    logic       MED_DSO;
    logic [7:0] RES_OUT;
    logic       RES_VALID;

    logic       dso_auto = 1'b0;
    logic [7:0] do_auto = '0;
    logic       dso_man = 1'b0;
    logic [7:0] do_man = '0;
    assign MED_DSO = dso_auto | dso_man;
    assign MED_DO  = dso_man ? do_man : do_auto;

    window_feeder #(.width(8), .IMG_W(IW), .IMG_H(IH)) dut (
        .CLK(CLK), .RST(RST), .PIX_IN(PIX_IN), .PIX_VALID(PIX_VALID),
        .PIX_READY(PIX_READY), .MED_DI(MED_DI), .MED_DSI(MED_DSI),
        .MED_NRST(MED_NRST), .MED_DO(MED_DO), .MED_DSO(MED_DSO),
        .RES_OUT(RES_OUT), .RES_VALID(RES_VALID)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    logic [71:0] exp_win [$];
    logic [8:0]  exp_res [$];
    logic [71:0] obs_win [$];
    logic [8:0]  obs_res [$];
    int rd_win = 0;
    int rd_res = 0;

    int nrst_low_cnt = 0;
    int dsi_cnt = 0;
    int res_valid_cnt = 0;
    int di_bad_cnt = 0;
    bit auto_resp = 1'b1;
    int feed_idx = 0;
    int auto_cnt = 0;
    logic [71:0] feed_pack = '0;
    logic [7:0]  med_val = '0;

    logic [7:0] img [IH][IW];
    int m_row = 0;
    int m_col = 0;

    function automatic logic [7:0] median9(input logic [71:0] w);
        logic [7:0] a [9];
        logic [7:0] t;
        for (int i = 0; i < 9; i++) a[i] = w[71-8*i -: 8];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        return a[4];
    endfunction

    // Median-stage stand-in: collects the serial window, answers after a random delay.
    always @(negedge CLK) begin
        if (RST) begin
            feed_idx = 0;
            auto_cnt = 0;
            dso_auto = 1'b0;
            do_auto  = '0;
        end else begin
            if (MED_NRST == 1'b0) nrst_low_cnt++;
            if (!MED_DSI && MED_DI !== 8'h00) di_bad_cnt++;
            if (auto_cnt == 1) begin
                dso_auto = 1'b1;
                do_auto  = med_val;
            end else begin
                dso_auto = 1'b0;
                do_auto  = '0;
            end
            if (auto_cnt > 0) auto_cnt--;
            if (MED_DSI) begin
                dsi_cnt++;
                feed_pack = {feed_pack[63:0], MED_DI};
                feed_idx++;
                if (feed_idx == 9) begin
                    obs_win.push_back(feed_pack);
                    med_val  = median9(feed_pack);
                    feed_idx = 0;
                    if (auto_resp) auto_cnt = 1 + int'($urandom_range(0, 5));
                end
            end
            if (RES_VALID) begin
                res_valid_cnt++;
                obs_res.push_back({PIX_READY, RES_OUT});
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [71:0] got, input logic [71:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_accept(input logic [7:0] v);
        logic [71:0] w;
        img[m_row][m_col] = v;
        if (m_row >= 2 && m_col >= 2) begin
            w = '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    w = {w[63:0], img[m_row-2+r][m_col-2+c]};
            exp_win.push_back(w);
            if (auto_resp) exp_res.push_back({1'b0, median9(w)});
        end
        m_col++;
        if (m_col == IW) begin
            m_col = 0;
            m_row++;
            if (m_row == IH) m_row = 0;
        end
    endtask

    task automatic model_reset();
        m_row = 0;
        m_col = 0;
        exp_win.delete();
        exp_res.delete();
    endtask

    // Returns at the negedge following the accepting edge.
    task automatic send_pix(input logic [7:0] v, input int gap);
        int n;
        PIX_VALID = 1'b0;
        repeat (gap) @(negedge CLK);
        PIX_IN = v;
        PIX_VALID = 1'b1;
        n = 0;
        while (PIX_READY !== 1'b1 && n < 500) begin
            @(negedge CLK);
            n++;
        end
        tests++;
        assert (n < 500) else begin
            fails++;
            $error("FAIL ready_timeout: observed ready=%b after %0d cycles, expected 1", PIX_READY, n);
        end
        if (n < 500) begin
            @(posedge CLK);
            model_accept(v);
        end
        @(negedge CLK);
        PIX_VALID = 1'b0;
        PIX_IN = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(PIX_READY === 1'b1 && obs_res.size() >= rd_res + exp_res.size()) && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        tests++;
        assert (n < 1000) else begin
            fails++;
            $error("FAIL idle_timeout: observed %0d results, expected %0d", obs_res.size(), rd_res + exp_res.size());
        end
    endtask

    task automatic check_obs();
        logic [71:0] ew;
        logic [8:0]  er;
        while (rd_win < obs_win.size()) begin
            ew = (exp_win.size() > 0) ? exp_win.pop_front() : 'x;
            chk_w("window", obs_win[rd_win], ew);
            rd_win++;
        end
        while (rd_res < obs_res.size()) begin
            er = (exp_res.size() > 0) ? exp_res.pop_front() : 'x;
            chk("result", 32'(obs_res[rd_res]), 32'(er));
            rd_res++;
        end
        chk("pending_windows", exp_win.size(), 0);
        chk("pending_results", exp_res.size(), 0);
    endtask

    task automatic warmup();
        int n0, d0;
        n0 = nrst_low_cnt;
        d0 = dsi_cnt;
        for (int i = 0; i < 18; i++) send_pix(8'(10 * (i / IW) + (i % IW)), 0);
        chk("warm_nrst", nrst_low_cnt - n0, 0);
        chk("warm_dsi", dsi_cnt - d0, 0);
        send_pix(8'd22, 0);
        chk("clr_nrst", 32'(MED_NRST), 32'd0);
        chk("clr_dsi", 32'(MED_DSI), 32'd0);
        for (int i = 0; i < 9; i++) begin
            @(negedge CLK);
            chk("feed_dsi", 32'(MED_DSI), 32'd1);
            chk("feed_di", 32'(MED_DI), 32'(10 * (i / 3) + (i % 3)));
        end
        @(negedge CLK);
        chk("after_feed_dsi", 32'(MED_DSI), 32'd0);
        chk("first_nrst_cnt", nrst_low_cnt - n0, 1);
        chk("first_dsi_cnt", dsi_cnt - d0, 9);
        wait_idle();
        check_obs();
    endtask

    initial begin
        int r0, w0;
        // Reset held for three cycles.
        repeat (3) @(negedge CLK);
        chk("rst_ready", 32'(PIX_READY), 32'd0);
        chk("rst_di", 32'(MED_DI), 32'd0);
        chk("rst_dsi", 32'(MED_DSI), 32'd0);
        chk("rst_nrst", 32'(MED_NRST), 32'd0);
        chk("rst_res_out", 32'(RES_OUT), 32'd0);
        chk("rst_res_valid", 32'(RES_VALID), 32'd0);
        RST = 1'b0;
        #1;
        chk("rel_ready", 32'(PIX_READY), 32'd1);
        chk("rel_nrst", 32'(MED_NRST), 32'd1);
        chk("rel_dsi", 32'(MED_DSI), 32'd0);

        warmup();

        // Rest of row 2 and row 3 up to column 5.
        for (int i = 19; i < 30; i++) send_pix(8'(10 * (i / IW) + (i % IW)), 0);
        wait_idle();
        check_obs();
        chk_w("order_3_5", (obs_win.size() > 0) ? obs_win[obs_win.size()-1] : 'x, 72'h0D0E0F171819212223);

        // Late median answer plus spurious strobes while idle.
        auto_resp = 1'b0;
        send_pix(8'd36, 0);
        repeat (10) @(negedge CLK);
        r0 = res_valid_cnt;
        repeat (40) @(negedge CLK);
        chk("wait_ready", 32'(PIX_READY), 32'd0);
        chk("wait_no_valid", res_valid_cnt - r0, 0);
        exp_res.push_back({1'b0, 8'h5A});
        dso_man = 1'b1;
        do_man = 8'h5A;
        @(negedge CLK);
        dso_man = 1'b0;
        do_man = '0;
        chk("out_valid", 32'(RES_VALID), 32'd1);
        chk("out_res", 32'(RES_OUT), 32'h5A);
        chk("out_ready", 32'(PIX_READY), 32'd0);
        @(negedge CLK);
        chk("post_out_valid", 32'(RES_VALID), 32'd0);
        chk("post_out_ready", 32'(PIX_READY), 32'd1);
        dso_man = 1'b1;
        do_man = 8'hFF;
        repeat (3) begin
            @(negedge CLK);
            chk("spur_valid", 32'(RES_VALID), 32'd0);
            chk("spur_res_hold", 32'(RES_OUT), 32'h5A);
        end
        dso_man = 1'b0;
        do_man = '0;
        auto_resp = 1'b1;
        chk("one_pulse", res_valid_cnt - r0, 1);
        check_obs();

        // Reset in the fourth feed cycle.
        send_pix(8'd37, 0);
        repeat (4) @(negedge CLK);
        chk("abort_in_feed", 32'(MED_DSI), 32'd1);
        r0 = res_valid_cnt;
        w0 = obs_win.size();
        RST = 1'b1;
        #1;
        chk("abort_dsi", 32'(MED_DSI), 32'd0);
        chk("abort_di", 32'(MED_DI), 32'd0);
        chk("abort_ready", 32'(PIX_READY), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        #1;
        chk("abort_rel_ready", 32'(PIX_READY), 32'd1);
        chk("abort_rel_nrst", 32'(MED_NRST), 32'd1);
        repeat (20) @(negedge CLK);
        chk("abort_no_valid", res_valid_cnt - r0, 0);
        chk("abort_no_window", obs_win.size() - w0, 0);
        warmup();

        // Two full frames with random data and random valid gaps.
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        for (int f = 0; f < 2; f++) begin
            r0 = res_valid_cnt;
            for (int i = 0; i < IW * IH; i++)
                send_pix(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
            wait_idle();
            check_obs();
            chk("frame_pulses", res_valid_cnt - r0, 36);
        end

        chk("di_outside_feed", di_bad_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
